// File: rtl/fetch_stage.sv
// Instruction-fetch stage: architectural PC, single-outstanding imem
// request/ready/rvalid handshake, stall skid buffer and IF/ID register.
// Optional feature macro: FETCH_ADEL_CHECK_EN (fetch address-error check).
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] next_pc,
  input  logic        stall,
  input  logic        flush,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_pc4,
  output logic        fetch_busy,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr,
  output logic        id_exc_adel
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] buf_instr_q;
  logic        req_q;
  logic        id_valid_q;
  logic [31:0] id_pc_q;
  logic [31:0] id_instr_q;
  logic        id_exc_adel_q;

  logic        adv;
  logic [31:0] adv_instr;
  logic        adv_adel;
  logic        pc_err;

  // Address-error predicate; constant 0 when the check is compiled out.
  function automatic logic addr_err(input logic [31:0] a);
`ifdef FETCH_ADEL_CHECK_EN
    return (a[1:0] != 2'b00) || (a < 32'h0000_3000) || (a > 32'h0000_6FFF);
`else
    return (a != a);
`endif
  endfunction

  assign pc_err = addr_err(pc_q);

  // Advance decode: which state completes the fetch of pc this cycle, and with what word.
  always_comb begin
    adv       = 1'b0;
    adv_instr = '0;
    adv_adel  = 1'b0;
    case (state_q)
      S_REQ: begin
        if (pc_err && !stall) begin
          adv      = 1'b1;
          adv_adel = 1'b1;
        end
      end
      S_WAIT: begin
        if (imem_rvalid && !stall) begin
          adv       = 1'b1;
          adv_instr = imem_rdata;
        end
      end
      S_HOLD: begin
        if (!stall) begin
          adv       = 1'b1;
          adv_instr = buf_instr_q;
        end
      end
      default: ;
    endcase
  end

  // Next state and next PC; flush deliberately plays no part here.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (pc_err) begin
          if (adv) pc_d = next_pc;
        end else if (imem_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) state_d = stall ? S_HOLD : S_REQ;
        if (adv)         pc_d    = next_pc;
      end
      S_HOLD: begin
        if (adv) begin
          state_d = S_REQ;
          pc_d    = next_pc;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM, PC, skid buffer and IF/ID registers; imem_req is precomputed from next state/PC.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      buf_instr_q   <= '0;
      req_q         <= 1'b0;
      id_valid_q    <= 1'b0;
      id_pc_q       <= '0;
      id_instr_q    <= '0;
      id_exc_adel_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      req_q   <= (state_d == S_REQ) && !addr_err(pc_d);
      if (state_q == S_WAIT && imem_rvalid && stall) begin
        buf_instr_q <= imem_rdata;
      end
      if (flush) begin
        id_valid_q    <= 1'b0;
        id_pc_q       <= '0;
        id_instr_q    <= '0;
        id_exc_adel_q <= 1'b0;
      end else if (adv) begin
        id_valid_q    <= 1'b1;
        id_pc_q       <= pc_q;
        id_instr_q    <= adv_instr;
        id_exc_adel_q <= adv_adel;
      end
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign if_pc4      = pc_q + 32'd4;
  assign fetch_busy  = !adv;
  assign id_valid    = id_valid_q;
  assign id_pc       = id_pc_q;
  assign id_instr    = id_instr_q;
  assign id_exc_adel = id_exc_adel_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed fetches push expected IF/ID
// contents; a negedge monitor pops and compares after every advance edge.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] next_pc;
  logic        stall;
  logic        flush;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] if_pc4;
  logic        fetch_busy;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic        id_exc_adel;

  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        adel;
    logic [31:0] npc;
  } exp_t;

  exp_t        exp_q[$];
  int          n_chk  = 0;
  int          n_fail = 0;
  bit          pend   = 1'b0;
  exp_t        e;
  logic [31:0] last_pc    = '0;
  logic [31:0] last_instr = '0;

  fetch_stage #(.RESET_PC(32'h0000_3000)) dut (
    .clk(clk), .reset_n(reset_n), .next_pc(next_pc), .stall(stall), .flush(flush),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .if_pc4(if_pc4),
    .fetch_busy(fetch_busy), .id_valid(id_valid), .id_pc(id_pc),
    .id_instr(id_instr), .id_exc_adel(id_exc_adel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Monitor: an advance edge follows any negedge where fetch_busy is low.
  initial begin
    forever begin
      @(negedge clk);
      if (pend) begin
        n_chk++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_empty: got advance expected none");
        end else begin
          e = exp_q.pop_front();
          chk("id_valid", {31'd0, id_valid}, {31'd0, e.valid});
          chk("id_pc", id_pc, e.pc);
          chk("id_instr", id_instr, e.instr);
          chk("id_exc_adel", {31'd0, id_exc_adel}, {31'd0, e.adel});
          chk("pc_after_adv", imem_addr, e.npc);
        end
      end
      pend = reset_n && !fetch_busy;
    end
  end

  task automatic push(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                      input logic ad, input logic [31:0] npc);
    exp_t x;
    x.valid = v; x.pc = pc; x.instr = ins; x.adel = ad; x.npc = npc;
    exp_q.push_back(x);
    if (v) begin
      last_pc    = pc;
      last_instr = ins;
    end else begin
      last_pc    = '0;
      last_instr = '0;
    end
  endtask

  // One fetch: ready after rdly cycles, rvalid vdly cycles after the ready
  // cycle, stall held stall_n cycles starting at rvalid, optional flush on advance.
  task automatic do_fetch(input logic [31:0] addr, input logic [31:0] ins,
                          input logic [31:0] npc, input int rdly, input int vdly,
                          input int stall_n, input bit fl);
    int t = 0;
    next_pc = npc;
    while (!imem_req && t < 20) begin
      step();
      t++;
    end
    chk("req_seen", {31'd0, imem_req}, 32'd1);
    chk("req_addr", imem_addr, addr);
    repeat (rdly) begin
      chk("busy_wait_ready", {31'd0, fetch_busy}, 32'd1);
      step();
      chk("pc_hold_ready", imem_addr, addr);
    end
    imem_ready = 1'b1;
    step();
    imem_ready = 1'b0;
    repeat (vdly - 1) begin
      chk("busy_wait_rvalid", {31'd0, fetch_busy}, 32'd1);
      chk("req_low_wait", {31'd0, imem_req}, 32'd0);
      step();
      chk("pc_hold_rvalid", imem_addr, addr);
    end
    imem_rvalid = 1'b1;
    imem_rdata  = ins;
    if (stall_n > 0) begin
      stall = 1'b1;
      chk("busy_stall", {31'd0, fetch_busy}, 32'd1);
      step();
      imem_rvalid = 1'b0;
      imem_rdata  = 32'hDEAD_BEEF;
      repeat (stall_n - 1) begin
        chk("busy_hold", {31'd0, fetch_busy}, 32'd1);
        chk("hold_id_pc", id_pc, last_pc);
        chk("hold_id_instr", id_instr, last_instr);
        chk("hold_pc", imem_addr, addr);
        step();
      end
      stall = 1'b0;
    end
    flush = fl;
    if (fl) push(1'b0, '0, '0, 1'b0, npc);
    else    push(1'b1, addr, ins, 1'b0, npc);
    step();
    imem_rvalid = 1'b0;
    imem_rdata  = 32'hDEAD_BEEF;
    flush       = 1'b0;
  endtask

  initial begin
    reset_n     = 1'b0;
    next_pc     = 32'h0000_3004;
    stall       = 1'b0;
    flush       = 1'b0;
    imem_ready  = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    step();
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, 32'h0000_3000);
    chk("rst_pc4", if_pc4, 32'h0000_3004);
    chk("rst_busy", {31'd0, fetch_busy}, 32'd1);
    chk("rst_id_valid", {31'd0, id_valid}, 32'd0);
    chk("rst_id_pc", id_pc, 32'd0);
    chk("rst_id_instr", id_instr, 32'd0);
    chk("rst_id_adel", {31'd0, id_exc_adel}, 32'd0);
    step();
    reset_n = 1'b1;
    chk("idle_req", {31'd0, imem_req}, 32'd0);
    step();
    chk("first_req", {31'd0, imem_req}, 32'd1);

    do_fetch(32'h0000_3000, 32'h2408_0001, 32'h0000_3004, 0, 1, 0, 1'b0);
    do_fetch(32'h0000_3004, 32'h8C09_0004, 32'h0000_3008, 3, 2, 0, 1'b0);
    do_fetch(32'h0000_3008, 32'hAD2A_0008, 32'h0000_300C, 0, 1, 4, 1'b0);
    do_fetch(32'h0000_300C, 32'h1000_FFFF, 32'h0000_3040, 0, 1, 0, 1'b1);
    do_fetch(32'h0000_3040, 32'h0109_5020, 32'h0000_3002, 0, 1, 0, 1'b0);

`ifdef FETCH_ADEL_CHECK_EN
    next_pc = 32'h0000_3008;
    chk("adel_no_req", {31'd0, imem_req}, 32'd0);
    chk("adel_addr", imem_addr, 32'h0000_3002);
    chk("adel_busy", {31'd0, fetch_busy}, 32'd0);
    push(1'b1, 32'h0000_3002, 32'h0, 1'b1, 32'h0000_3008);
    step();
`else
    chk("misaligned_req", {31'd0, imem_req}, 32'd1);
    do_fetch(32'h0000_3002, 32'h3C0B_1234, 32'h0000_3008, 0, 1, 0, 1'b0);
`endif

    do_fetch(32'h0000_3008, 32'h0000_0020, 32'h0000_300C, 1, 3, 2, 1'b0);

    // Stall pulse while in REQ must not disturb the request.
    stall = 1'b1;
    step();
    chk("req_stall_req", {31'd0, imem_req}, 32'd1);
    chk("req_stall_addr", imem_addr, 32'h0000_300C);
    step();
    stall = 1'b0;
    do_fetch(32'h0000_300C, 32'h2129_FFFF, 32'h0000_3010, 0, 1, 0, 1'b0);

    // Reset while WAIT, then a stray rvalid in IDLE.
    next_pc    = 32'h0000_3014;
    imem_ready = 1'b1;
    step();
    imem_ready = 1'b0;
    reset_n    = 1'b0;
    #1;
    chk("mid_rst_id_valid", {31'd0, id_valid}, 32'd0);
    chk("mid_rst_addr", imem_addr, 32'h0000_3000);
    step();
    reset_n     = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hBAD0_BAD0;
    chk("stray_busy", {31'd0, fetch_busy}, 32'd1);
    step();
    imem_rvalid = 1'b0;
    chk("stray_id_valid", {31'd0, id_valid}, 32'd0);
    do_fetch(32'h0000_3000, 32'h2408_0002, 32'hFFFF_FFFC, 0, 1, 0, 1'b0);
    stall = 1'b1;
    chk("pc4_wrap", if_pc4, 32'h0000_0000);
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);

    repeat (3) step();
    chk("sb_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined MIPS core. It holds the architectural PC, issues one instruction-memory request at a time over a request/ready/rvalid handshake, and loads the IF/ID pipeline register. It consumes the next-PC value produced by the ID-stage next-PC selector and supplies that selector with the sequential address `if_pc4`. Branches are delayed, so the stage never squashes the instruction that follows a branch on its own.

## Interface
- `RESET_PC`, default 32'h0000_3000: PC value loaded on reset.
- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `next_pc`  in  32  next PC from the ID-stage next-PC selector.
- `stall`  in  1  hazard-unit freeze of the PC and IF/ID.
- `flush`  in  1  clear IF/ID to a bubble at the next edge.
- `imem_req`  out  1  fetch request valid.
- `imem_addr`  out  32  fetch address, equal to `pc`.
- `imem_ready`  in  1  memory accepts the request this cycle.
- `imem_rvalid`  in  1  read data valid.
- `imem_rdata`  in  32  instruction word.
- `if_pc4`  out  32  `pc + 4`, combinational; feeds the selector's sequential input.
- `fetch_busy`  out  1  fetch for `pc` not yet completed.
- `id_valid`  out  1  IF/ID holds a real instruction.
- `id_pc`  out  32  PC of the IF/ID instruction.
- `id_instr`  out  32  IF/ID instruction; 0 (nop) when invalid.
- `id_exc_adel`  out  1  fetch address error for the IF/ID instruction.

## Operation
- Registers:
  - `pc`.
  - FSM state.
  - Skid buffer: `buf_instr`.
  - IF/ID: `id_valid`, `id_pc`, `id_instr`, `id_exc_adel`.
- FSM states:
  - IDLE: reset state. Goes to REQ unconditionally on the next edge.
  - REQ: `imem_req`=1. On `imem_ready`, goes to WAIT.
  - WAIT: On `imem_rvalid`, if `stall`=0 it advances and goes to REQ. If `stall`=1 it stores `imem_rdata` in `buf_instr` and goes to HOLD.
  - HOLD: When `stall`=0, advances from `buf_instr` and goes to REQ.
- `imem_req` is 1 only in REQ. `imem_addr` = `pc` in every state.
- Advance (a single edge):
  - `pc <= next_pc`.
  - IF/ID <= {valid 1, `pc`, instruction, adel}.
- `fetch_busy` = 1 unless an advance condition holds this cycle. The hazard unit must freeze ID and bubble EX while `fetch_busy`=1, so `next_pc` stays stable until the advance.
- `flush`:
  - Loads IF/ID with {0, 0, 0, 0} at the next edge.
  - Has priority over both advance and `stall` for IF/ID only.
  - `pc` and the FSM behave as if `flush` were absent.
- `stall`=1 with no `flush`: `pc` and IF/ID hold.
- `imem_rvalid` outside WAIT is ignored. At most one request is outstanding.
- Arithmetic: `if_pc4` is a 32-bit add and wraps modulo 2^32.

## Timing
- Reset values:
  - `pc` = `RESET_PC`; state = IDLE.
  - `imem_req` = 0; `imem_addr` = `RESET_PC`; `if_pc4` = `RESET_PC` + 4; `fetch_busy` = 1.
  - `id_valid` = 0, `id_pc` = 0, `id_instr` = 0, `id_exc_adel` = 0; `buf_instr` = 0.
- First request: `imem_req` rises in the first cycle after `reset_n` deasserts plus one edge (IDLE→REQ).
- Zero-wait memory (`imem_ready` same cycle, `imem_rvalid` next cycle): one instruction every 2 cycles. Path: REQ→WAIT, then advance back to REQ.
- Latency: IF/ID updates on the edge where `imem_rvalid`=1 and `stall`=0. `id_*` are visible the following cycle.
- Reset mid-request: the in-flight fetch is abandoned. The memory shares `reset_n` and must drop any pending response.
- `stall` that rises and falls while in REQ does not affect the request.

## Configuration
- Macro `FETCH_ADEL_CHECK_EN`.
- Defined: in REQ, the stage checks `pc[1:0]`≠0 or `pc` outside [0x0000_3000, 0x0000_6FFF]. If so:
  - No request is issued.
  - The fetch counts as complete: it advances when `stall`=0 with `id_instr`=0 and `id_exc_adel`=1.
- Not defined: there is no check and `id_exc_adel` is constant 0.

## Test plan
- Reset release, zero-wait memory returning 0x2408_0001: `imem_addr`=0x3000 is requested. The cycle after rvalid shows `id_pc`=0x3000, `id_instr`=0x2408_0001, `id_valid`=1, and `pc` = `next_pc`.
- Memory with `imem_ready` delayed 3 cycles and rvalid 2 cycles later: `fetch_busy`=1 throughout and `pc` is unchanged until the rvalid edge.
- rvalid arrives with `stall`=1 for 4 cycles: FSM enters HOLD and IF/ID holds the old value. On the first `stall`=0 edge, IF/ID gets the buffered word.
- `flush`=1 on the advance edge with `next_pc`=0x3040: IF/ID becomes all zeros and `pc`=0x3040.
- `next_pc`=0x3002 with `FETCH_ADEL_CHECK_EN`: `imem_req` stays 0; `id_exc_adel`=1, `id_pc`=0x3002, `id_instr`=0. Without the macro, the request is issued at 0x3002.
- `reset_n` asserted during WAIT, then a stray rvalid arrives in IDLE: it is ignored, and the first post-reset `id_pc` is 0x3000.
